// File: rtl/pwl_activation_interp_pipe_if.sv
// ---------------------------------------------------------------------------
// pwl_activation_interp_pipe_if
// Bundles the sample stream, the result stream and the breakpoint-table
// write port of the piecewise-linear activation unit.
//   in_valid/in_ready/in_x/in_mode    : sample stream into the unit
//   out_valid/out_ready/out_y         : result stream out of the unit
//   tbl_we/tbl_addr/tbl_wdata         : breakpoint table write port
//   busy                              : any pipeline stage holds a word
// master = producer/consumer side (bench or neighbouring layers),
// slave  = the activation unit itself.
// ---------------------------------------------------------------------------
interface pwl_activation_interp_pipe_if #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_x;
  logic                     in_mode;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_y;
  logic                     tbl_we;
  logic [IDX_W:0]           tbl_addr;
  logic signed [DATA_W-1:0] tbl_wdata;
  logic                     busy;

  modport master (
    output in_valid, in_x, in_mode, out_ready, tbl_we, tbl_addr, tbl_wdata,
    input  in_ready, out_valid, out_y, busy
  );

  modport slave (
    input  in_valid, in_x, in_mode, out_ready, tbl_we, tbl_addr, tbl_wdata,
    output in_ready, out_valid, out_y, busy
  );
endinterface

// File: rtl/pwl_activation_interp_pipe.sv
// ---------------------------------------------------------------------------
// pwl_activation_interp_pipe
// Three-stage piecewise-linear activation unit. The signed input is offset
// to unsigned, split into a table index (upper IDX_W bits) and a remainder
// (lower REM_W bits), and the result is linearly interpolated between two
// adjacent entries of a run-time-writable breakpoint table:
//   y = base + ((next - base) * rem >>> REM_W)
// in_mode=1 selects nearest mode (base entry only).
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active-low
//   bus  : slave side of pwl_activation_interp_pipe_if (streams, table port,
//          busy flag)
// Stages: S1 captures index data and both table entries, S2 forms the
// scaled difference, S3 adds it to the base and drives out_y.
// ---------------------------------------------------------------------------
module pwl_activation_interp_pipe #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 4
) (
  input logic                          clk,
  input logic                          rst,
  pwl_activation_interp_pipe_if.slave  bus
);
  localparam int REM_W  = DATA_W - IDX_W;
  localparam int DEPTH  = (2 ** IDX_W) + 1;
  localparam int PROD_W = DATA_W + REM_W + 2;

  // Breakpoint table and pipeline registers
  logic signed [DATA_W-1:0] r_tbl [DEPTH];

  logic                     r_s1_v;
  logic [REM_W-1:0]         r_s1_rem;
  logic                     r_s1_mode;
  logic signed [DATA_W-1:0] r_s1_base;
  logic signed [DATA_W-1:0] r_s1_next;

  logic                     r_s2_v;
  logic signed [DATA_W-1:0] r_s2_base;
  logic signed [PROD_W-1:0] r_s2_prod;

  logic                     r_s3_v;
  logic signed [DATA_W-1:0] r_s3_y;

  logic                     w_s1_load;
  logic                     w_s2_load;
  logic                     w_s3_load;
  logic [DATA_W-1:0]        w_u;
  logic [IDX_W:0]           w_idx;
  logic [IDX_W:0]           w_idx_nx;
  logic [REM_W-1:0]         w_rem;
  logic signed [PROD_W-1:0] w_diff;
  logic signed [PROD_W-1:0] w_rem_ext;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [DATA_W-1:0] w_y;

  // A stage loads when it is empty or its downstream stage drains this
  // cycle; chaining the enables lets bubbles collapse.
  assign w_s3_load = !r_s3_v || bus.out_ready;
  assign w_s2_load = !r_s2_v || w_s3_load;
  assign w_s1_load = !r_s1_v || w_s2_load;

  // Adding 2**(DATA_W-1) to a two's-complement value is an MSB flip.
  assign w_u      = {~bus.in_x[DATA_W-1], bus.in_x[DATA_W-2:0]};
  assign w_idx    = {1'b0, w_u[DATA_W-1:REM_W]};
  assign w_idx_nx = w_idx + (IDX_W+1)'(1);
  assign w_rem    = w_u[REM_W-1:0];

  // S1 -> S2 arithmetic: signed difference times zero-extended remainder.
  // NOTE: every always_comb output is assigned unconditionally first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    w_diff    = PROD_W'(r_s1_next) - PROD_W'(r_s1_base);
    w_rem_ext = PROD_W'({1'b0, r_s1_rem});
    w_prod    = '0;
    if (!r_s1_mode) begin
      w_prod = w_diff * w_rem_ext;
    end
  end

  // S2 -> S3: arithmetic shift floors toward -inf; the result lies between
  // base and next, so truncating to DATA_W cannot overflow.
  assign w_y = r_s2_base + DATA_W'(r_s2_prod >>> REM_W);

  // NOTE: all state uses non-blocking assignments, so an S1 read of an entry
  // written in the same cycle sees the value from before that edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the table is reset along with the pipeline because a freshly
      // reset unit must return 0 for any input; this keeps it out of RAM.
      for (int i = 0; i < DEPTH; i++) begin
        r_tbl[i] <= '0;
      end
      r_s1_v    <= 1'b0;
      r_s1_rem  <= '0;
      r_s1_mode <= 1'b0;
      r_s1_base <= '0;
      r_s1_next <= '0;
      r_s2_v    <= 1'b0;
      r_s2_base <= '0;
      r_s2_prod <= '0;
      r_s3_v    <= 1'b0;
      r_s3_y    <= '0;
    end else begin
      // Out-of-range addresses are dropped silently.
      if (bus.tbl_we && (int'(bus.tbl_addr) < DEPTH)) begin
        r_tbl[bus.tbl_addr] <= bus.tbl_wdata;
      end

      if (w_s1_load) begin
        r_s1_v <= bus.in_valid;
        if (bus.in_valid) begin
          r_s1_rem  <= w_rem;
          r_s1_mode <= bus.in_mode;
          r_s1_base <= r_tbl[w_idx];
          r_s1_next <= r_tbl[w_idx_nx];
        end
      end

      if (w_s2_load) begin
        r_s2_v <= r_s1_v;
        if (r_s1_v) begin
          r_s2_base <= r_s1_base;
          r_s2_prod <= w_prod;
        end
      end

      // out_y keeps its last value across bubbles and stalls.
      if (w_s3_load) begin
        r_s3_v <= r_s2_v;
        if (r_s2_v) begin
          r_s3_y <= w_y;
        end
      end
    end
  end

  assign bus.in_ready  = w_s1_load;
  assign bus.out_valid = r_s3_v;
  assign bus.out_y     = r_s3_y;
  assign bus.busy      = r_s1_v | r_s2_v | r_s3_v;

endmodule

// File: tb/tb_pwl_activation_interp_pipe.sv
// ---------------------------------------------------------------------------
// tb_pwl_activation_interp_pipe
// Directed bench for pwl_activation_interp_pipe at DATA_W=8, IDX_W=4.
// Inputs change 1 ns after the rising edge; outputs are sampled at the same
// point, so a word seen with out_valid&&out_ready is taken at the next edge.
// With tbl[i]=8*i-64 the unit computes floor((x+128)/2)-64 == x>>>1, which
// the streaming tests use as their expected-value model.
// ---------------------------------------------------------------------------
module tb_pwl_activation_interp_pipe;
  localparam int DATA_W = 8;
  localparam int IDX_W  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;

  pwl_activation_interp_pipe_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) io ();

  pwl_activation_interp_pipe #(.DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (io)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_tbl(input int addr, input int data);
    io.tbl_we    = 1'b1;
    io.tbl_addr  = 5'(addr);
    io.tbl_wdata = 8'(data);
    tick();
    io.tbl_we    = 1'b0;
  endtask

  task automatic load_ascending();
    for (int i = 0; i <= 16; i++) write_tbl(i, 8 * i - 64);
  endtask

  // Take results in order with out_ready=1 until the queue empties.
  task automatic collect(input string nm, input int exp[$]);
    int budget = 0;
    int e;
    io.out_ready = 1'b1;
    while (exp.size() > 0 && budget < 40) begin
      if (io.out_valid) begin
        e = exp.pop_front();
        n_cmp++;
        if (io.out_y !== 8'(e)) begin
          n_mis++;
          $display("FAIL %s: out_y=%0d expected %0d", nm, $signed(io.out_y), e);
        end
      end
      tick();
      budget++;
    end
    if (exp.size() > 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL %s timeout: %0d results missing, expected 0", nm, exp.size());
    end
  endtask

  task automatic run_one(input string nm, input logic signed [7:0] x,
                         input logic m, input int e);
    int q[$];
    int b = 0;
    io.out_ready = 1'b1;
    io.in_valid  = 1'b1;
    io.in_x      = x;
    io.in_mode   = m;
    while (!io.in_ready && b < 20) begin
      tick();
      b++;
    end
    tick();
    io.in_valid = 1'b0;
    io.in_mode  = 1'b0;
    q.push_back(e);
    collect(nm, q);
  endtask

  task automatic test_reset();
    io.in_valid  = 1'b0;
    io.in_x      = '0;
    io.in_mode   = 1'b0;
    io.out_ready = 1'b0;
    io.tbl_we    = 1'b0;
    io.tbl_addr  = '0;
    io.tbl_wdata = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    n_cmp++;
    if (io.out_valid !== 1'b0) begin
      n_mis++; $display("FAIL reset out_valid: got %b expected 0", io.out_valid);
    end
    n_cmp++;
    if (io.busy !== 1'b0) begin
      n_mis++; $display("FAIL reset busy: got %b expected 0", io.busy);
    end
    n_cmp++;
    if (io.in_ready !== 1'b1) begin
      n_mis++; $display("FAIL reset in_ready: got %b expected 1", io.in_ready);
    end
    n_cmp++;
    if (io.out_y !== 8'sd0) begin
      n_mis++; $display("FAIL reset out_y: got %0d expected 0", $signed(io.out_y));
    end
    run_one("reset table x=0", 8'sd0, 1'b0, 0);
    run_one("reset table x=-128", -8'sd128, 1'b0, 0);
    run_one("reset table x=127", 8'sd127, 1'b0, 0);
  endtask

  task automatic test_interp();
    load_ascending();
    run_one("interp x=0", 8'sd0, 1'b0, 0);
    run_one("interp x=5", 8'sd5, 1'b0, 2);
    run_one("interp x=-3", -8'sd3, 1'b0, -2);
    run_one("interp x=-128", -8'sd128, 1'b0, -64);
    // idx 15, rem 15: tbl[15]=56, tbl[16]=64 -> 56 + (8*15>>>4) = 63
    run_one("interp x=127", 8'sd127, 1'b0, 63);
  endtask

  task automatic test_negative_slope_and_mode();
    for (int i = 0; i <= 16; i++) write_tbl(i, 64 - 8 * i);
    run_one("desc x=5", 8'sd5, 1'b0, -3);     // 0 + floor(-40/16)
    run_one("desc x=-3", -8'sd3, 1'b0, 1);    // 8 + floor(-104/16)
    run_one("nearest x=5", 8'sd5, 1'b1, 0);
    run_one("nearest x=-3", -8'sd3, 1'b1, 8);
  endtask

  task automatic test_back_to_back();
    int q[$];
    int sent = 0, got = 0, cyc = 0, e;
    int acc_first = -1, acc_last = -1, out_first = -1;
    logic signed [7:0] xv;
    load_ascending();
    io.out_ready = 1'b1;
    while (got < 10 && cyc < 100) begin
      if (io.out_valid) begin
        if (out_first < 0) out_first = cyc;
        n_cmp++;
        if (q.size() == 0) begin
          n_mis++;
          $display("FAIL b2b unexpected word: out_y=%0d expected none", $signed(io.out_y));
        end else begin
          e = q.pop_front();
          if (io.out_y !== 8'(e)) begin
            n_mis++;
            $display("FAIL b2b word %0d: out_y=%0d expected %0d", got, $signed(io.out_y), e);
          end
        end
        got++;
      end
      if (sent < 10) begin
        xv = 8'(sent * 23 - 100);
        io.in_valid = 1'b1;
        io.in_x     = xv;
        io.in_mode  = 1'b0;
      end else begin
        io.in_valid = 1'b0;
      end
      if (io.in_valid && io.in_ready) begin
        if (acc_first < 0) acc_first = cyc;
        acc_last = cyc;
        q.push_back(int'(xv) >>> 1);
        sent++;
      end
      tick();
      cyc++;
    end
    io.in_valid = 1'b0;
    n_cmp++;
    if (got != 10) begin
      n_mis++; $display("FAIL b2b count: got %0d results expected 10", got);
    end
    n_cmp++;
    if (out_first - acc_first != 3) begin
      n_mis++; $display("FAIL b2b latency: %0d cycles expected 3", out_first - acc_first);
    end
    n_cmp++;
    if (acc_last - acc_first != 9) begin
      n_mis++; $display("FAIL b2b throughput: 10 accepts over %0d cycles expected 10", acc_last - acc_first + 1);
    end
  endtask

  task automatic test_backpressure();
    int q[$];
    int acc = 0;
    logic signed [7:0] xv;
    logic [7:0] held = '0;
    bit seen = 1'b0, stable = 1'b1;
    io.out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (io.out_valid) begin
        if (!seen) begin
          held = io.out_y;
          seen = 1'b1;
        end else if (io.out_y !== held) begin
          stable = 1'b0;
        end
      end
      xv = 8'(acc * 19 - 40);
      io.in_valid = (acc < 5);
      io.in_x     = xv;
      io.in_mode  = 1'b0;
      if (io.in_valid && io.in_ready) begin
        q.push_back(int'(xv) >>> 1);
        acc++;
      end
      tick();
    end
    n_cmp++;
    if (acc != 3) begin
      n_mis++; $display("FAIL stall accepted: %0d words expected 3", acc);
    end
    n_cmp++;
    if (io.in_ready !== 1'b0) begin
      n_mis++; $display("FAIL stall in_ready: got %b expected 0", io.in_ready);
    end
    n_cmp++;
    if (!(seen && stable)) begin
      n_mis++; $display("FAIL stall out_y hold: seen=%b stable=%b expected 1 1", seen, stable);
    end
    n_cmp++;
    if (io.busy !== 1'b1) begin
      n_mis++; $display("FAIL stall busy: got %b expected 1", io.busy);
    end
    io.in_valid = 1'b0;
    collect("stall drain", q);
  endtask

  task automatic test_table_collision();
    int q[$];
    io.out_ready = 1'b1;
    io.tbl_we    = 1'b1;
    io.tbl_addr  = 5'd8;
    io.tbl_wdata = 8'sd20;
    io.in_valid  = 1'b1;
    io.in_x      = 8'sd0;
    io.in_mode   = 1'b0;
    n_cmp++;
    if (io.in_ready !== 1'b1) begin
      n_mis++; $display("FAIL collision in_ready: got %b expected 1", io.in_ready);
    end
    tick();
    io.tbl_we = 1'b0;
    tick();
    io.in_valid = 1'b0;
    q.push_back(0);   // accepted with the write: old tbl[8]
    q.push_back(20);  // accepted next cycle: new tbl[8]
    collect("collision", q);
    write_tbl(31, 99);
    run_one("oob tbl[15]", 8'sd112, 1'b0, 56);
    run_one("oob tbl[16]", 8'sd127, 1'b0, 63);
    run_one("oob tbl[0]", -8'sd128, 1'b0, -64);
    run_one("oob tbl[8]", 8'sd0, 1'b0, 20);
  endtask

  task automatic test_reset_inflight();
    int acc = 0, b = 0, stale = 0;
    io.out_ready = 1'b0;
    io.in_x      = 8'sd5;
    io.in_mode   = 1'b0;
    while (acc < 3 && b < 10) begin
      io.in_valid = 1'b1;
      if (io.in_ready) acc++;
      tick();
      b++;
    end
    n_cmp++;
    if (io.out_valid !== 1'b1) begin
      n_mis++; $display("FAIL inflight fill out_valid: got %b expected 1", io.out_valid);
    end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (io.out_valid !== 1'b0) begin
      n_mis++; $display("FAIL inflight reset out_valid: got %b expected 0", io.out_valid);
    end
    n_cmp++;
    if (io.busy !== 1'b0) begin
      n_mis++; $display("FAIL inflight reset busy: got %b expected 0", io.busy);
    end
    io.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    io.out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (io.out_valid) stale++;
      tick();
    end
    n_cmp++;
    if (stale != 0) begin
      n_mis++; $display("FAIL inflight stale output: %0d words expected 0", stale);
    end
    // tbl[8]=20 before reset would give 16 here; a cleared table gives 0.
    run_one("inflight table cleared", 8'sd5, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_interp();
    test_negative_slope_and_mode();
    test_back_to_back();
    test_backpressure();
    test_table_collision();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
